// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the TPU multiplier datapath.
// Class encoding, exception flag positions and width-derived constants.
package fp_pkg;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } fp_class_e;

    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_INVALID   = 3;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int fp_emax(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // Quiet NaN: positive sign, all-ones exponent, mantissa MSB set.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] r;
        r = 64'(fp_emax(exp_w)) << man_w;
        r = r | (64'd1 << (man_w - 1));
        return r;
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a stored mantissa given guard and sticky.
// carry_o flags a mantissa wrap that the caller turns into exponent+1.
module fp_round_rne
    import fp_pkg::*;
#(
    parameter int MAN_W = 10
) (
    input  logic [MAN_W-1:0] man_i,
    input  logic             guard_i,
    input  logic             sticky_i,
    output logic [MAN_W-1:0] man_o,
    output logic             carry_o
);

    logic           inc;
    logic [MAN_W:0] sum;

    always_comb begin
        inc     = guard_i & (sticky_i | man_i[0]);
        sum     = {1'b0, man_i} + {{MAN_W{1'b0}}, inc};
        man_o   = sum[MAN_W-1:0];
        carry_o = sum[MAN_W];
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow
// control, round-to-nearest-even, special-value handling and a sideband tag.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     z,
    output logic [TAG_W-1:0]         out_tag,
    output logic [3:0]               flags
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int XW = EXP_W + 2;

    localparam logic [XW-1:0]    BIAS_X = XW'(fp_bias(EXP_W));
    localparam logic [XW-1:0]    EMAX_X = XW'(fp_emax(EXP_W));
    localparam logic [EXP_W-1:0] EMAX_E = EXP_W'(fp_emax(EXP_W));
    localparam logic [W-1:0]     QNAN   = W'(fp_qnan(EXP_W, MAN_W));

    typedef struct packed {
        logic             sign;
        fp_class_e        ca;
        fp_class_e        cb;
        logic [XW-1:0]    exp;
        logic [PW-1:0]    prod;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic             sign;
        fp_class_e        ca;
        fp_class_e        cb;
        logic [XW-1:0]    exp;
        logic [MAN_W-1:0] man;
        logic             inexact;
        logic [TAG_W-1:0] tag;
    } s2_t;

    function automatic fp_class_e classify(
        input logic [EXP_W-1:0] e,
        input logic [MAN_W-1:0] m
    );
        fp_class_e c;
        unique case (1'b1)
            (e == '0):                 c = ZERO;
            (e == EMAX_E && m == '0):  c = INF;
            (e == EMAX_E && m != '0):  c = NAN;
            default:                   c = NORM;
        endcase
        return c;
    endfunction

    logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    s1_t              s1_q, s1_d, s1_new;
    s2_t              s2_q, s2_d, s2_new;
    logic [W-1:0]     z_q, z_d, z_new;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [3:0]       flags_q, flags_d, flags_new;
    logic             load1, load2, load3;

    // Each stage moves when it is empty or its successor moves.
    always_comb begin
        load3    = !v3_q || out_ready;
        load2    = !v2_q || load3;
        load1    = !v1_q || load2;
        in_ready = load1;
    end

    always_comb begin
        s1_new      = '0;
        s1_new.sign = a[W-1] ^ b[W-1];
        s1_new.ca   = classify(a[W-2 -: EXP_W], a[MAN_W-1:0]);
        s1_new.cb   = classify(b[W-2 -: EXP_W], b[MAN_W-1:0]);
        s1_new.exp  = XW'(a[W-2 -: EXP_W]) + XW'(b[W-2 -: EXP_W]) - BIAS_X;
        s1_new.prod = PW'({1'b1, a[MAN_W-1:0]}) * PW'({1'b1, b[MAN_W-1:0]});
        s1_new.tag  = in_tag;
    end

    logic             hi;
    logic [MAN_W-1:0] man_pre, man_rnd;
    logic             guard, sticky, carry;

    always_comb begin
        hi      = s1_q.prod[PW-1];
        man_pre = hi ? s1_q.prod[PW-2 -: MAN_W] : s1_q.prod[PW-3 -: MAN_W];
        guard   = hi ? s1_q.prod[MAN_W] : s1_q.prod[MAN_W-1];
        sticky  = hi ? |s1_q.prod[MAN_W-1:0] : |s1_q.prod[MAN_W-2:0];
    end

    fp_round_rne #(
        .MAN_W    (MAN_W)
    ) u_round (
        .man_i    (man_pre),
        .guard_i  (guard),
        .sticky_i (sticky),
        .man_o    (man_rnd),
        .carry_o  (carry)
    );

    always_comb begin
        s2_new         = '0;
        s2_new.sign    = s1_q.sign;
        s2_new.ca      = s1_q.ca;
        s2_new.cb      = s1_q.cb;
        s2_new.exp     = s1_q.exp + XW'(hi) + XW'(carry);
        s2_new.man     = man_rnd;
        s2_new.inexact = guard | sticky;
        s2_new.tag     = s1_q.tag;
    end

    logic any_nan, inf_x_zero, any_inf, any_zero, ovf, unf;

    always_comb begin
        any_nan    = (s2_q.ca == NAN) || (s2_q.cb == NAN);
        inf_x_zero = (s2_q.ca == INF && s2_q.cb == ZERO) ||
                     (s2_q.ca == ZERO && s2_q.cb == INF);
        any_inf    = (s2_q.ca == INF) || (s2_q.cb == INF);
        any_zero   = (s2_q.ca == ZERO) || (s2_q.cb == ZERO);
        ovf        = !s2_q.exp[XW-1] && (s2_q.exp >= EMAX_X);
        unf        = s2_q.exp[XW-1] || (s2_q.exp == '0);
        z_new      = '0;
        flags_new  = '0;
        if (any_nan || inf_x_zero) begin
            z_new                   = QNAN;
            flags_new[FLAG_INVALID] = inf_x_zero;
        end else if (any_inf) begin
            z_new = {s2_q.sign, EMAX_E, {MAN_W{1'b0}}};
        end else if (any_zero) begin
            z_new = {s2_q.sign, {(W-1){1'b0}}};
        end else if (ovf) begin
            z_new                    = {s2_q.sign, EMAX_E, {MAN_W{1'b0}}};
            flags_new[FLAG_OVERFLOW] = 1'b1;
            flags_new[FLAG_INEXACT]  = 1'b1;
        end else if (unf) begin
            z_new                     = {s2_q.sign, {(W-1){1'b0}}};
            flags_new[FLAG_UNDERFLOW] = 1'b1;
            flags_new[FLAG_INEXACT]   = 1'b1;
        end else begin
            z_new                   = {s2_q.sign, s2_q.exp[EXP_W-1:0], s2_q.man};
            flags_new[FLAG_INEXACT] = s2_q.inexact;
        end
    end

    always_comb begin
        v1_d      = load1 ? in_valid : v1_q;
        v2_d      = load2 ? v1_q : v2_q;
        v3_d      = load3 ? v2_q : v3_q;
        s1_d      = (load1 && in_valid) ? s1_new : s1_q;
        s2_d      = (load2 && v1_q) ? s2_new : s2_q;
        z_d       = z_q;
        out_tag_d = out_tag_q;
        flags_d   = flags_q;
        if (load3 && v2_q) begin
            z_d       = z_new;
            out_tag_d = s2_q.tag;
            flags_d   = flags_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            s1_q      <= '0;
            s2_q      <= '0;
            z_q       <= '0;
            out_tag_q <= '0;
            flags_q   <= '0;
        end else begin
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            v3_q      <= v3_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            z_q       <= z_d;
            out_tag_q <= out_tag_d;
            flags_q   <= flags_d;
        end
    end

    assign out_valid = v3_q;
    assign z         = z_q;
    assign out_tag   = out_tag_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for the fp16 configuration of fp_mul_pipe.
// Covers latency, rounding, specials, backpressure and mid-flight reset.
module tb_fp_mul_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, z;
    logic [3:0]  in_tag, out_tag, flags;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] z;
        logic [3:0]  f;
        logic [3:0]  t;
    } exp_t;

    exp_t sb[$];

    // {a, b, expected z, expected {invalid, overflow, underflow, inexact}}
    localparam int NV = 14;
    logic [51:0] vt [NV];

    fp_mul_pipe #(
        .EXP_W     (5),
        .MAN_W     (10),
        .TAG_W     (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .out_tag   (out_tag),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (z !== 16'h0000) begin
            failures++;
            $display("FAIL reset_z got=%h exp=0000", z);
        end
        checks++;
        if (out_tag !== 4'h0 || flags !== 4'h0) begin
            failures++;
            $display("FAIL reset_tag_flags got=%h/%h exp=0/0", out_tag, flags);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_single();
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            a = vt[i][51:36];
            b = vt[i][35:20];
            in_tag = i[3:0];
            in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL single_in_ready[%0d] got=%b exp=1", i, in_ready);
            end
            sb.push_back({vt[i][19:4], vt[i][3:0], i[3:0]});
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!out_valid && n < 10);
            checks++;
            if (n !== 3) begin
                failures++;
                $display("FAIL single_latency[%0d] got=%0d exp=3", i, n);
            end
            e = sb.pop_front();
            checks++;
            if (z !== e.z) begin
                failures++;
                $display("FAIL single_z[%0d] %h*%h got=%h exp=%h", i, a, b, z, e.z);
            end
            checks++;
            if (flags !== e.f) begin
                failures++;
                $display("FAIL single_flags[%0d] got=%b exp=%b", i, flags, e.f);
            end
            checks++;
            if (out_tag !== e.t) begin
                failures++;
                $display("FAIL single_tag[%0d] got=%h exp=%h", i, out_tag, e.t);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        fork
            begin : drv
                int   idx = 0;
                logic acc;
                for (int cyc = 0; cyc < 100 && idx < NV; cyc++) begin
                    a = vt[idx][51:36];
                    b = vt[idx][35:20];
                    in_tag = idx[3:0];
                    in_valid = 1'b1;
                    @(negedge clk);
                    acc = in_ready;
                    @(posedge clk);
                    if (acc) begin
                        sb.push_back({vt[idx][19:4], vt[idx][3:0], idx[3:0]});
                        idx++;
                    end
                    #1;
                end
                in_valid = 1'b0;
            end
            begin : mon
                int   got = 0;
                exp_t e;
                for (int cyc = 0; cyc < 100 && got < NV; cyc++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        checks++;
                        if (sb.size() == 0) begin
                            failures++;
                            $display("FAIL b2b_extra got tag=%h exp=none", out_tag);
                        end else begin
                            e = sb.pop_front();
                            if (z !== e.z || flags !== e.f || out_tag !== e.t) begin
                                failures++;
                                $display("FAIL b2b_result got=%h/%b/%h exp=%h/%b/%h",
                                         z, flags, out_tag, e.z, e.f, e.t);
                            end
                        end
                        got++;
                    end else if (got > 0) begin
                        checks++;
                        failures++;
                        $display("FAIL b2b_gap got out_valid=0 exp=1 after %0d", got);
                    end
                end
                checks++;
                if (got !== NV) begin
                    failures++;
                    $display("FAIL b2b_count got=%0d exp=%0d", got, NV);
                end
            end
        join
    endtask

    task automatic test_backpressure();
        int   nxt = 1;
        int   seen = 0;
        logic acc;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            a = 16'h3C00;
            b = {12'h400, nxt[3:0]};
            in_tag = nxt[3:0];
            in_valid = 1'b1;
            @(negedge clk);
            acc = in_ready;
            if (out_valid && sb.size() > 0) begin
                seen++;
                checks++;
                if (out_tag !== sb[0].t || z !== sb[0].z) begin
                    failures++;
                    $display("FAIL stall_hold got=%h/%h exp=%h/%h",
                             out_tag, z, sb[0].t, sb[0].z);
                end
            end
            @(posedge clk);
            if (acc) begin
                sb.push_back({12'h400, nxt[3:0], 4'h0, nxt[3:0]});
                nxt++;
            end
            #1;
        end
        checks++;
        if (nxt - 1 !== 3) begin
            failures++;
            $display("FAIL stall_accepted got=%0d exp=3", nxt - 1);
        end
        checks++;
        if (seen < 1) begin
            failures++;
            $display("FAIL stall_out_valid got=%0d cycles exp>=1", seen);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_in_ready got=%b exp=0", in_ready);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        fork
            begin : drv
                logic acc2;
                for (int cyc = 0; cyc < 40 && nxt <= 5; cyc++) begin
                    a = 16'h3C00;
                    b = {12'h400, nxt[3:0]};
                    in_tag = nxt[3:0];
                    in_valid = 1'b1;
                    @(negedge clk);
                    acc2 = in_ready;
                    @(posedge clk);
                    if (acc2) begin
                        sb.push_back({12'h400, nxt[3:0], 4'h0, nxt[3:0]});
                        nxt++;
                    end
                    #1;
                end
                in_valid = 1'b0;
            end
            begin : mon
                int   got = 0;
                exp_t e;
                for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        checks++;
                        if (sb.size() == 0) begin
                            failures++;
                            $display("FAIL bp_extra got tag=%h exp=none", out_tag);
                        end else begin
                            e = sb.pop_front();
                            if (out_tag !== e.t || z !== e.z || flags !== e.f) begin
                                failures++;
                                $display("FAIL bp_order got=%h/%h exp=%h/%h",
                                         out_tag, z, e.t, e.z);
                            end
                        end
                        got++;
                    end else if (got > 0) begin
                        checks++;
                        failures++;
                        $display("FAIL bp_gap got out_valid=0 exp=1 after %0d", got);
                    end
                end
                checks++;
                if (got !== 5) begin
                    failures++;
                    $display("FAIL bp_count got=%0d exp=5", got);
                end
            end
        join
    endtask

    task automatic test_reset_inflight();
        int   n;
        int   stale = 0;
        exp_t e;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            a = 16'h3C00;
            b = {12'h400, i[3:0]};
            in_tag = i[3:0];
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL inflight_full got=%b exp=1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (z !== 16'h0000 || out_tag !== 4'h0 || flags !== 4'h0) begin
            failures++;
            $display("FAIL rst_outputs got=%h/%h/%h exp=0/0/0", z, out_tag, flags);
        end
        sb.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checks++;
        if (stale !== 0) begin
            failures++;
            $display("FAIL rst_stale got=%0d valid cycles exp=0", stale);
        end
        @(posedge clk);
        #1;
        a = 16'h4000;
        b = 16'h4000;
        in_tag = 4'h7;
        in_valid = 1'b1;
        sb.push_back({16'h4400, 4'h0, 4'h7});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        checks++;
        if (n !== 3) begin
            failures++;
            $display("FAIL post_rst_latency got=%0d exp=3", n);
        end
        e = sb.pop_front();
        checks++;
        if (z !== e.z || flags !== e.f || out_tag !== e.t) begin
            failures++;
            $display("FAIL post_rst_result got=%h/%b/%h exp=%h/%b/%h",
                     z, flags, out_tag, e.z, e.f, e.t);
        end
    endtask

    initial begin
        vt = '{
            {16'h3C00, 16'h4000, 16'h4000, 4'b0000},
            {16'h3E00, 16'h3E00, 16'h4080, 4'b0000},
            {16'hC000, 16'h3C00, 16'hC000, 4'b0000},
            {16'h3C01, 16'h3C01, 16'h3C02, 4'b0001},
            {16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101},
            {16'h7C00, 16'h0000, 16'h7E00, 4'b1000},
            {16'h7E00, 16'h3C00, 16'h7E00, 4'b0000},
            {16'hFC00, 16'h4000, 16'hFC00, 4'b0000},
            {16'h0400, 16'h3800, 16'h0000, 4'b0011},
            {16'h0001, 16'h3C00, 16'h0000, 4'b0000},
            {16'h4000, 16'h4000, 16'h4400, 4'b0000},
            {16'h3E00, 16'h3C01, 16'h3E02, 4'b0001},
            {16'h3E00, 16'h3C03, 16'h3E04, 4'b0001},
            {16'h3DA8, 16'h3DA8, 16'h4000, 4'b0001}
        };
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
